// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter
//
// Round-robin owner of a single W-bit shared register. Up to N requesters
// compete for the register; one winner per decision has its data loaded and
// is told so through a registered one-hot grant. The current owner may keep
// the register, and keep rewriting it, for at most MAX_HOLD consecutive
// cycles by holding both req and lock. This block is the only writer of the
// shared flop bank.
//
// Ports
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   req     per-requester request (held until the requester sees its grant)
//   lock    per-requester hold request, only honoured for the current owner
//   wdata   requester i data at bits [i*W +: W]
//   gnt     registered one-hot grant, all-zero when idle
//   owner   index of the current or most recent owner
//   busy    register currently owned
//   qout    shared register contents
//   valid   qout has been written at least once since reset
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | nobody owns the register; gnt=0, qout/owner/valid hold
// OWNED  | owner holds the register; extend on lock or release/regrant

module reg_share_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4,
    localparam int AW      = (N > 1) ? $clog2(N) : 1,
    localparam int HW      = $clog2(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    input  logic [N*W-1:0]  wdata,
    output logic [N-1:0]    gnt,
    output logic [AW-1:0]   owner,
    output logic            busy,
    output logic [W-1:0]    qout,
    output logic            valid
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t         state;
    logic [AW-1:0]  ptr;
    logic [HW-1:0]  hold_cnt;

    logic           win_found;
    logic [AW-1:0]  win_idx;
    logic [AW-1:0]  win_next;
    logic [N-1:0]   win_onehot;
    logic [W-1:0]   win_data;
    logic [W-1:0]   own_data;
    logic           extend;
    logic           do_grant;
    logic           do_release;

    // Index ptr+offset wrapped into 0..N-1 (offset is always < N).
    function automatic logic [AW-1:0] rr_index(input logic [AW-1:0] base,
                                                input int offset);
        int s;
        s = int'(base) + offset;
        if (s >= N) begin
            s = s - N;
        end
        return AW'(s);
    endfunction

    // Scan from the highest offset down so the request closest to ptr is the
    // last one written and therefore wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[rr_index(ptr, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(ptr, k);
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
        win_next            = (win_idx == AW'(N - 1)) ? '0 : win_idx + AW'(1);
        win_data            = wdata[int'(win_idx) * W +: W];
        own_data            = wdata[int'(owner) * W +: W];
    end

    // Extension needs the owner's own req and lock; a lock from anybody else
    // never counts, and a locked owner is forced out once hold_cnt saturates.
    always_comb begin
        extend     = (state == S_OWNED) && req[owner] && lock[owner]
                     && (hold_cnt < HW'(MAX_HOLD));
        do_grant   = win_found && !extend;
        do_release = (state == S_OWNED) && !extend && !win_found;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            qout     <= '0;
            valid    <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else if (do_grant) begin
            // Covers both a grant from IDLE and a back-to-back handover from
            // OWNED; ptr already points past the old owner so it ranks last.
            state    <= S_OWNED;
            gnt      <= win_onehot;
            owner    <= win_idx;
            busy     <= 1'b1;
            qout     <= win_data;
            valid    <= 1'b1;
            ptr      <= win_next;
            hold_cnt <= HW'(1);
        end else if (extend) begin
            qout     <= own_data;
            hold_cnt <= hold_cnt + HW'(1);
        end else if (do_release) begin
            state    <= S_IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
module tb_reg_share_arbiter;

    localparam int N        = 4;
    localparam int W        = 8;
    localparam int MAX_HOLD = 4;
    localparam int AW       = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*W-1:0]  wdata;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   owner;
    logic            busy;
    logic [W-1:0]    qout;
    logic            valid;

    logic [W-1:0]    wd [N];

    typedef struct {
        string          name;
        logic [N-1:0]   gnt;
        logic [AW-1:0]  owner;
        logic           busy;
        logic [W-1:0]   qout;
        logic           valid;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    reg_share_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .qout  (qout),
        .valid (valid)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input string name, input logic [N-1:0] g,
                                input logic [AW-1:0] o, input logic b,
                                input logic [W-1:0] q, input logic v);
        exp_t e;
        e.name  = name;
        e.gnt   = g;
        e.owner = o;
        e.busy  = b;
        e.qout  = q;
        e.valid = v;
        return e;
    endfunction

    // Drive inputs, take one clock edge, then queue the expected outputs.
    task automatic step(input string name, input logic [N-1:0] r,
                        input logic [N-1:0] l, input logic [N-1:0] eg,
                        input logic [AW-1:0] eo, input logic eb,
                        input logic [W-1:0] eq, input logic ev);
        req   = r;
        lock  = l;
        wdata = {wd[3], wd[2], wd[1], wd[0]};
        @(posedge clk);
        #1;
        sb.push_back(mk(name, eg, eo, eb, eq, ev));
    endtask

    // Monitor: compare whatever expectation is pending on each falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if ({gnt, owner, busy, qout, valid} !==
                {mon_e.gnt, mon_e.owner, mon_e.busy, mon_e.qout, mon_e.valid}) begin
                errors++;
                $display("FAIL %s: got gnt=%b owner=%0d busy=%b qout=%h valid=%b, expected gnt=%b owner=%0d busy=%b qout=%h valid=%b",
                         mon_e.name, gnt, owner, busy, qout, valid,
                         mon_e.gnt, mon_e.owner, mon_e.busy, mon_e.qout, mon_e.valid);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        for (int i = 0; i < N; i++) wd[i] = '0;
        wdata = '0;

        // Reset state
        step("reset_state", 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;

        // Single request then release to idle
        wd[1] = 8'hA5;
        step("single_grant", 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 8'hA5, 1'b1);
        step("single_release", 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 8'hA5, 1'b1);

        // Idle hold: data changes must not be captured
        for (int i = 0; i < N; i++) wd[i] = 8'hFF;
        for (int c = 0; c < 10; c++)
            step("idle_hold", 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 8'hA5, 1'b1);

        // Owner 2 locks, then async reset mid-ownership (ptr=2 -> wins 2)
        wd[2] = 8'h77;
        step("pre_reset_grant2", 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 8'h77, 1'b1);
        wd[2] = 8'h78;
        step("pre_reset_extend", 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 8'h78, 1'b1);
        wd[2]  = 8'h79;
        wdata  = {wd[3], wd[2], wd[1], wd[0]};
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        sb.push_back(mk("async_reset", 4'b0000, 2'd0, 1'b0, 8'h00, 1'b0));
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Round-robin wrap with everybody requesting; first grant goes to 0
        for (int i = 0; i < N; i++) wd[i] = 8'h10 + 8'(i);
        step("rr_0", 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 8'h10, 1'b1);
        step("rr_1", 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 8'h11, 1'b1);
        step("rr_2", 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1, 8'h12, 1'b1);
        step("rr_3", 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 8'h13, 1'b1);
        step("rr_wrap", 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 8'h10, 1'b1);

        // Non-owner lock: owner 2 with lock only on requester 0
        step("nonowner_setup", 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 8'h12, 1'b1);
        step("nonowner_lock", 4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, 8'h10, 1'b1);

        // Move ptr back to 0 via requester 3, then go idle
        step("ptr_to_0", 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 8'h13, 1'b1);
        step("idle_again", 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 8'h13, 1'b1);

        // Lock bound: owner 0 keeps the register for exactly MAX_HOLD cycles
        wd[1] = 8'hB1;
        wd[0] = 8'h00;
        step("lock_c1", 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, 8'h00, 1'b1);
        wd[0] = 8'h01;
        step("lock_c2", 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, 8'h01, 1'b1);
        wd[0] = 8'h02;
        step("lock_c3", 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, 8'h02, 1'b1);
        wd[0] = 8'h03;
        step("lock_c4", 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, 8'h03, 1'b1);
        wd[0] = 8'h04;
        step("lock_forced_release", 4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b1, 8'hB1, 1'b1);
        wd[0] = 8'h05;
        step("lock_regain", 4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, 8'h05, 1'b1);

        // Lock without req does not extend
        step("lock_noreq", 4'b0010, 4'b0001, 4'b0010, 2'd1, 1'b1, 8'hB1, 1'b1);
        step("final_idle", 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 8'hB1, 1'b1);

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin controller that shares one W-bit asynchronous-reset storage register among N requesters. Each requester presents data and a request; the arbiter selects one winner per decision, loads that requester's data into the shared register, and signals ownership with a one-hot grant. A lock input lets the owner keep the register and rewrite it for a bounded number of cycles. It sits between the requesting datapath blocks and the shared flop bank and is the only writer of that bank.

## Interface
- N, 4: number of requesters (N >= 2)
- W, 8: shared register width
- MAX_HOLD, 4: maximum consecutive owned cycles per grant (>= 1)
- AW, $clog2(N): owner index width (derived)
- clk  input  1  clock, rising edge active
- reset  input  1  asynchronous, active-high reset
- req  input  N  per-requester request
- lock  input  N  per-requester hold request; only meaningful for the current owner
- wdata  input  N*W  requester i data at bits [i*W +: W]
- gnt  output  N  registered one-hot grant; all-zero when idle
- owner  output  AW  index of current or last owner
- busy  output  1  register currently owned
- qout  output  W  shared register contents
- valid  output  1  qout written at least once since reset

## Operation
- State: IDLE, OWNED. Internal: ptr (AW bits, round-robin start index), hold_cnt ($clog2(MAX_HOLD+1) bits).
- Reset (asynchronous, takes effect immediately, including mid-ownership): state=IDLE, gnt=0, owner=0, busy=0, qout=0, valid=0, ptr=0, hold_cnt=0.
- Winner selection (combinational): first i with req[i]=1 scanning ptr, ptr+1, ..., wrapping modulo N.
- Grant action (edge with a winner w): gnt<=onehot(w), owner<=w, qout<=wdata[w], valid<=1, busy<=1, hold_cnt<=1, ptr<=(w+1) mod N (wrap N-1 -> 0), state<=OWNED.
- IDLE: if req!=0, perform a grant action. Otherwise all outputs hold and gnt stays 0.
- OWNED, extend: if req[owner]=1, lock[owner]=1 and hold_cnt<MAX_HOLD, then qout<=wdata[owner], hold_cnt++, and gnt/owner/ptr are unchanged.
- OWNED, release (any other case): if req!=0, perform a grant action directly (back-to-back, no idle cycle). Because ptr already points past the old owner, the old owner has lowest priority. Otherwise state<=IDLE, gnt<=0, busy<=0, while qout, owner and valid hold.
- lock from a non-owner is ignored. lock without req does not extend ownership.
- With MAX_HOLD=1, every grant lasts exactly one cycle.
- gnt has at most one bit set at all times.

## Timing
- Latency: if req is sampled at edge k, then gnt, qout, owner and busy are valid after edge k (1 cycle). The captured data is wdata at edge k.
- The requester must hold req until it sees gnt[i]=1. Seeing gnt[i]=1 confirms that qout holds its data.
- Locked ownership lasts at most MAX_HOLD consecutive cycles. After that, the owner is forcibly released, and it re-enters the rotation only if no other requester is pending.
- Fairness: a continuously requesting requester is granted within (N-1)*MAX_HOLD+1 cycles of its request first being sampled.
- Only qout changes on extend cycles. gnt has no glitch or drop between extend cycles.

## Test plan
- Reset check: assert reset mid-OWNED with gnt=4'b0100, async and no clock edge. Required: gnt=0, busy=0, qout=0, valid=0, owner=0 immediately. The first grant after reset with req=4'b1111 goes to requester 0.
- Single request: req=4'b0010 with wdata[1]=8'hA5 for one edge, then req=0. Required: after 1 edge gnt=4'b0010, qout=8'hA5, owner=1, busy=1, valid=1. After the next edge gnt=0, busy=0, and qout stays 8'hA5.
- Round-robin wrap: req=4'b1111 held, lock=0, wdata[i]=8'h10+i. Required: gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with qout 8'h10, 8'h11, 8'h12, 8'h13, 8'h10.
- Lock bound: MAX_HOLD=4, req=4'b0011, lock=4'b0001, and wdata[0] incrementing each cycle from 8'h00. Required: gnt=0001 for exactly 4 cycles with qout 00, 01, 02, 03, then gnt=0010 and qout=wdata[1]. Requester 0 regains the grant only after requester 1 releases.
- Non-owner lock: owner=2 with lock=4'b0001 and req=4'b0101. Required: ownership is not extended, and the next grant goes to requester 0 on the following edge.
- Idle hold: from IDLE, req=0 for 10 cycles. Required: gnt=0, busy=0, and qout/owner/valid unchanged from prior values.
